// File: rtl/ring_trans_ctrl.sv
// Ring-buffer to event-buffer transfer controller: one address load, then SAMP_MAX+1 samples of WORDS_PER_SMP reads per L1A.
// Define RING_TRANS_TIMEOUT_EN to abandon an event after TMO_CYCLES consecutive wait cycles.
module ring_trans_ctrl #(
  parameter int unsigned SMP_W         = 7,
  parameter int unsigned SEQ_W         = 7,
  parameter int unsigned WORDS_PER_SMP = 95,
  parameter int unsigned EVT_CNT_W     = 12,
  parameter int unsigned TMO_CYCLES    = 4095
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 L1A_BUF_MT,
  input  logic                 RING_AMT,
  input  logic                 EVT_BUF_AFL,
  input  logic                 EVT_BUF_AMT,
  input  logic [SMP_W-1:0]     SAMP_MAX,
  output logic                 LD_ADDR,
  output logic                 RD,
  output logic                 NXT_L1A,
  output logic                 BUSY,
  output logic [SEQ_W-1:0]     SEQ,
  output logic [SMP_W-1:0]     SMP,
  output logic [EVT_CNT_W-1:0] EVT_CNT,
  output logic                 TMO,
  output logic [2:0]           EVT_STATE
);

  localparam int unsigned WAIT_W = 12;
  localparam logic [SEQ_W-1:0] LAST_SEQ = SEQ_W'(WORDS_PER_SMP - 1);

  // Elaboration-time parameter sanity
  if (WORDS_PER_SMP < 1 || WORDS_PER_SMP > (1 << SEQ_W)) begin : g_bad_wps
    $error("WORDS_PER_SMP out of range for SEQ_W");
  end
  if (TMO_CYCLES < 1 || TMO_CYCLES > ((1 << WAIT_W) - 1)) begin : g_bad_tmo
    $error("TMO_CYCLES out of range for the wait counter");
  end

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_ADDR  = 3'd1,
    W4DATA     = 3'd2,
    READ       = 3'd3,
    SMP_END    = 3'd4,
    W4_EVT_AMT = 3'd5,
    NEXT_L1A   = 3'd6
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [SEQ_W-1:0]     seq_nxt;
  logic [SMP_W-1:0]     smp_nxt;
  logic [EVT_CNT_W-1:0] evt_nxt;

`ifdef RING_TRANS_TIMEOUT_EN
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_wait_c;
  logic              tmo_hit_c;

  assign in_wait_c = (state == W4DATA) || (state == W4_EVT_AMT);
  assign tmo_hit_c = in_wait_c && (wait_cnt == WAIT_W'(TMO_CYCLES - 1));
`endif

  // Next-state and counter updates
  always_comb begin
    next_state = state;
    seq_nxt    = SEQ;
    smp_nxt    = SMP;
    evt_nxt    = EVT_CNT;
    case (state)
      IDLE: begin
        seq_nxt = '0;
        smp_nxt = '0;
        if (!L1A_BUF_MT) next_state = LOAD_ADDR;
      end
      LOAD_ADDR: next_state = W4DATA;
      W4DATA: begin
        if (!RING_AMT) next_state = EVT_BUF_AFL ? W4_EVT_AMT : READ;
      end
      READ: begin
        if (SEQ == LAST_SEQ) begin
          seq_nxt    = '0;
          next_state = SMP_END;
        end else begin
          seq_nxt = SEQ + SEQ_W'(1);
          if (EVT_BUF_AFL)   next_state = W4_EVT_AMT;
          else if (RING_AMT) next_state = W4DATA;
        end
      end
      SMP_END: begin
        if (SMP == SAMP_MAX) begin
          smp_nxt    = '0;
          next_state = NEXT_L1A;
        end else begin
          smp_nxt = SMP + SMP_W'(1);
          if (EVT_BUF_AFL)   next_state = W4_EVT_AMT;
          else if (RING_AMT) next_state = W4DATA;
          else               next_state = READ;
        end
      end
      W4_EVT_AMT: begin
        if (EVT_BUF_AMT) next_state = W4DATA;
      end
      NEXT_L1A: begin
        evt_nxt    = EVT_CNT + EVT_CNT_W'(1);
        next_state = IDLE;
      end
      default: begin
        seq_nxt    = '0;
        smp_nxt    = '0;
        next_state = IDLE;
      end
    endcase
`ifdef RING_TRANS_TIMEOUT_EN
    // Stalled too long: drop the rest of the event but still retire the L1A
    if (tmo_hit_c) begin
      seq_nxt    = '0;
      smp_nxt    = '0;
      next_state = NEXT_L1A;
    end
`endif
  end

  // State register with strobes decoded from the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      LD_ADDR <= 1'b0;
      RD      <= 1'b0;
      NXT_L1A <= 1'b0;
      BUSY    <= 1'b0;
      SEQ     <= '0;
      SMP     <= '0;
      EVT_CNT <= '0;
    end else begin
      state   <= next_state;
      LD_ADDR <= (next_state == LOAD_ADDR);
      RD      <= (next_state == READ);
      NXT_L1A <= (next_state == NEXT_L1A);
      BUSY    <= (next_state != IDLE);
      SEQ     <= seq_nxt;
      SMP     <= smp_nxt;
      EVT_CNT <= evt_nxt;
    end
  end

  assign EVT_STATE = state;

`ifdef RING_TRANS_TIMEOUT_EN
  // Consecutive wait-state cycle counter and sticky timeout flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= '0;
      TMO      <= 1'b0;
    end else begin
      wait_cnt <= in_wait_c ? wait_cnt + WAIT_W'(1) : '0;
      if (tmo_hit_c) TMO <= 1'b1;
    end
  end
`else
  assign TMO = 1'b0;
`endif

endmodule

// File: tb/tb_ring_trans_ctrl.sv
// Scoreboard bench for ring_trans_ctrl: expected strobe stream per L1A, plus entry-rule checks on RD and wait routing.
module tb_ring_trans_ctrl;

  localparam int unsigned SMP_W     = 7;
  localparam int unsigned SEQ_W     = 7;
  localparam int unsigned WPS       = 4;
  localparam int unsigned EVT_CNT_W = 12;
  localparam int          EVT_MOD   = 4096;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 L1A_BUF_MT;
  logic                 RING_AMT;
  logic                 EVT_BUF_AFL;
  logic                 EVT_BUF_AMT;
  logic [SMP_W-1:0]     SAMP_MAX;
  logic                 LD_ADDR;
  logic                 RD;
  logic                 NXT_L1A;
  logic                 BUSY;
  logic [SEQ_W-1:0]     SEQ;
  logic [SMP_W-1:0]     SMP;
  logic [EVT_CNT_W-1:0] EVT_CNT;
  logic                 TMO;
  logic [2:0]           EVT_STATE;

  ring_trans_ctrl #(
    .SMP_W(SMP_W), .SEQ_W(SEQ_W), .WORDS_PER_SMP(WPS), .EVT_CNT_W(EVT_CNT_W), .TMO_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST), .L1A_BUF_MT(L1A_BUF_MT), .RING_AMT(RING_AMT),
    .EVT_BUF_AFL(EVT_BUF_AFL), .EVT_BUF_AMT(EVT_BUF_AMT), .SAMP_MAX(SAMP_MAX),
    .LD_ADDR(LD_ADDR), .RD(RD), .NXT_L1A(NXT_L1A), .BUSY(BUSY), .SEQ(SEQ), .SMP(SMP),
    .EVT_CNT(EVT_CNT), .TMO(TMO), .EVT_STATE(EVT_STATE)
  );

  always #5 CLK = ~CLK;

  typedef enum int {K_LD = 0, K_RD = 1, K_NXT = 2} kind_t;
  typedef struct {
    kind_t kind;
    int    seq;
    int    smp;
    int    evt;
  } item_t;

  item_t sb_q[$];
  int    pending = 0;
  int    exp_evt = 0;
  int    checks  = 0;
  int    errors  = 0;
  int    ld_cnt  = 0;
  int    rd_cnt  = 0;
  int    nxt_cnt = 0;
  bit    mon_en  = 1'b0;
  bit    rnd_en  = 1'b0;

  // FIFO is empty exactly when no issued L1A is still waiting to be popped
  assign L1A_BUF_MT = (pending == 0);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected strobe stream for one L1A, from the transfer rules
  task automatic issue_l1a(input int smax);
    sb_q.push_back('{K_LD, 0, 0, 0});
    for (int s = 0; s <= smax; s++)
      for (int w = 0; w < int'(WPS); w++)
        sb_q.push_back('{K_RD, w, s, 0});
    sb_q.push_back('{K_NXT, 0, 0, exp_evt});
    exp_evt = (exp_evt + 1) % EVT_MOD;
    pending++;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (rnd_en) begin
      RING_AMT    = ($urandom_range(3) == 0);
      EVT_BUF_AFL = ($urandom_range(4) == 0);
      EVT_BUF_AMT = ($urandom_range(2) == 0);
    end
  endtask

  task automatic clean_inputs();
    RING_AMT    = 1'b0;
    EVT_BUF_AFL = 1'b0;
    EVT_BUF_AMT = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((pending != 0 || BUSY) && n < budget) begin
      step();
      n++;
    end
    chk(name, int'(pending != 0 || BUSY), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    sb_q.delete();
    pending = 0;
    exp_evt = 0;
    step();
    step();
    RST = 1'b0;
  endtask

  logic       prev_ring, prev_afl, prev_rst;
  logic [2:0] prev_state;
  always @(posedge CLK) begin
    prev_ring  <= RING_AMT;
    prev_afl   <= EVT_BUF_AFL;
    prev_rst   <= RST;
    prev_state <= EVT_STATE;
  end

  // Monitor: pops expectations on every strobe and checks the entry rules
  always @(negedge CLK) begin : mon
    item_t it;
    int    kind_act;
    int    state_exp;
    if (mon_en && !RST && !prev_rst) begin
      chk("busy_vs_state", int'(BUSY), int'(EVT_STATE != 3'd0));
      if (RD) chk("rd_needs_data_and_space", int'({prev_ring, prev_afl}), 0);
      if (prev_state == 3'd2 && !prev_ring && prev_afl) chk("afl_routes_to_w4evt", int'(EVT_STATE), 5);
      if (prev_state == 3'd2 && prev_ring) chk("ring_amt_holds_w4data", int'(EVT_STATE), 2);
      if (LD_ADDR) ld_cnt++;
      if (RD) rd_cnt++;
      if (NXT_L1A) begin
        nxt_cnt++;
        if (pending > 0) pending--;
      end
      if (LD_ADDR || RD || NXT_L1A) begin
        chk("one_strobe", int'(LD_ADDR) + int'(RD) + int'(NXT_L1A), 1);
        if (sb_q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          it = sb_q.pop_front();
          kind_act  = LD_ADDR ? int'(K_LD) : (RD ? int'(K_RD) : int'(K_NXT));
          state_exp = (it.kind == K_LD) ? 1 : ((it.kind == K_RD) ? 3 : 6);
          chk("strobe_kind", kind_act, int'(it.kind));
          chk("seq", int'(SEQ), it.seq);
          chk("smp", int'(SMP), it.smp);
          chk("state_code", int'(EVT_STATE), state_exp);
          if (it.kind == K_NXT) chk("evt_cnt_at_nxt", int'(EVT_CNT), it.evt);
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, rd0, ld0, nxt0, k;
    RST = 1'b1;
    SAMP_MAX = SMP_W'(1);
    clean_inputs();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ld_addr", int'(LD_ADDR), 0);
    chk("rst_rd", int'(RD), 0);
    chk("rst_nxt_l1a", int'(NXT_L1A), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_seq", int'(SEQ), 0);
    chk("rst_smp", int'(SMP), 0);
    chk("rst_evt_cnt", int'(EVT_CNT), 0);
    chk("rst_tmo", int'(TMO), 0);
    chk("rst_state", int'(EVT_STATE), 0);
    RST = 1'b0;
    mon_en = 1'b1;
    step();

    // Best-case event, two samples, no stalls
    rd0 = rd_cnt;
    issue_l1a(1);
    n = 0;
    do begin
      step();
      n++;
    end while (!NXT_L1A && n < 100);
    chk("best_case_latency", n, 2 + 2 * (int'(WPS) + 1) + 1);
    step();
    chk("busy_drops_after_nxt", int'(BUSY), 0);
    chk("best_case_rd_total", rd_cnt - rd0, 2 * int'(WPS));
    chk("evt_cnt_one", int'(EVT_CNT), 1);

    // Event-buffer almost-full during the second word of sample 0
    rd0 = rd_cnt;
    issue_l1a(1);
    n = 0;
    while (!(RD && SEQ == SEQ_W'(1)) && n < 50) begin step(); n++; end
    chk("reach_second_rd", int'(RD && SEQ == SEQ_W'(1)), 1);
    EVT_BUF_AFL = 1'b1;
    EVT_BUF_AMT = 1'b0;
    step();
    chk("afl_stops_rd", int'(RD), 0);
    chk("afl_seq_held", int'(SEQ), 2);
    EVT_BUF_AFL = 1'b0;
    repeat (4) step();
    chk("paused_no_rd_seq", int'({RD, SEQ}), 2);
    EVT_BUF_AMT = 1'b1;
    step();
    EVT_BUF_AMT = 1'b0;
    step();
    chk("resume_rd", int'(RD), 1);
    chk("resume_seq", int'(SEQ), 2);
    EVT_BUF_AMT = 1'b1;
    wait_idle(200, "afl_event_done");
    chk("afl_rd_total", rd_cnt - rd0, 2 * int'(WPS));

    // Ring almost-empty hold, then AFL wins as data arrives
    RING_AMT = 1'b1;
    rd0 = rd_cnt;
    issue_l1a(1);
    n = 0;
    while (!LD_ADDR && n < 20) begin step(); n++; end
    chk("ld_addr_seen", int'(LD_ADDR), 1);
    repeat (10) step();
    chk("w4data_while_amt", int'(EVT_STATE), 2);
    chk("no_rd_while_amt", rd_cnt - rd0, 0);
    RING_AMT = 1'b0;
    EVT_BUF_AFL = 1'b1;
    EVT_BUF_AMT = 1'b0;
    step();
    chk("afl_before_any_rd", int'(EVT_STATE), 5);
    chk("afl_no_rd", int'(RD), 0);
    clean_inputs();
    wait_idle(200, "amt_event_done");

    // Reset in READ at SEQ=3, SMP=1: abort without popping the FIFO
    issue_l1a(1);
    n = 0;
    while (!(RD && SEQ == SEQ_W'(3) && SMP == SMP_W'(1)) && n < 50) begin step(); n++; end
    chk("reach_last_word", int'(RD && SEQ == SEQ_W'(3) && SMP == SMP_W'(1)), 1);
    nxt0 = nxt_cnt;
    RST = 1'b1;
    sb_q.delete();
    pending = 0;
    exp_evt = 0;
    step();
    chk("midrst_outputs", int'({LD_ADDR, RD, NXT_L1A, BUSY, TMO}), 0);
    chk("midrst_seq_smp", int'({SEQ, SMP}), 0);
    chk("midrst_state", int'(EVT_STATE), 0);
    chk("midrst_evt_cnt", int'(EVT_CNT), 0);
    RST = 1'b0;
    repeat (5) step();
    chk("midrst_no_nxt", nxt_cnt - nxt0, 0);

    // Randomized stalls with random sample counts
    for (int b = 0; b < 8; b++) begin
      SAMP_MAX = SMP_W'($urandom_range(3));
      k = int'($urandom_range(1, 4));
      for (int i = 0; i < k; i++) issue_l1a(int'(SAMP_MAX));
      rnd_en = 1'b1;
      wait_idle(8000, "random_batch_done");
      rnd_en = 1'b0;
      clean_inputs();
      step();
    end

    // Back-to-back events until the event counter wraps
    do_reset();
    SAMP_MAX = '0;
    clean_inputs();
    ld0  = ld_cnt;
    nxt0 = nxt_cnt;
    for (int i = 0; i < EVT_MOD; i++) issue_l1a(0);
    wait_idle(EVT_MOD * 12, "wrap_events_done");
    chk("wrap_evt_cnt", int'(EVT_CNT), 0);
    chk("wrap_ld_count", ld_cnt - ld0, EVT_MOD);
    chk("wrap_nxt_count", nxt_cnt - nxt0, EVT_MOD);
    chk("sb_drained", sb_q.size(), 0);
    chk("tmo_stays_low", int'(TMO), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
